// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM state encoding and default widths for the ALU sequencer
package alu_seq_pkg;
   localparam int DEF_SIZE = 16;
   localparam int DEF_SHW  = 4;
   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_DRTAC = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_OR    = 4'd4;
   localparam logic [3:0] OP_AND   = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_COM   = 4'd7;
   localparam logic [3:0] OP_SHL   = 4'd8;
   localparam logic [3:0] OP_SHR   = 4'd9;
   localparam logic [3:0] OP_CLR   = 4'd10;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: opcode plus execute enable to one-hot ALU control lines and illegal flag
module alu_ctrl_decode
   import alu_seq_pkg::*;
(
   input  logic       i_en,
   input  logic [3:0] i_op,
   output logic [8:0] o_ctrl,
   output logic       o_illegal
);
   // Bit n-1 drives the control line of opcode n; NOP, CLR and illegal codes drive nothing
   assign o_ctrl    = (i_en && i_op >= OP_ADD && i_op <= OP_SHR) ? 9'(1) << (i_op - OP_ADD) : '0;
   assign o_illegal = i_op > OP_CLR;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU operation at a time, sequences the ALU and owns AC and its flags
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int SIZE = DEF_SIZE,
   parameter int SHW  = DEF_SHW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [SIZE-1:0] req_dr,
   input  logic [SHW-1:0]  req_shamt,
   output logic [SIZE-1:0] alu_dr,
   output logic [SIZE-1:0] alu_ac,
   output logic            alu_add,
   output logic            alu_drtac,
   output logic            alu_sub,
   output logic            alu_or,
   output logic            alu_and,
   output logic            alu_xor,
   output logic            alu_com,
   output logic            alu_shl,
   output logic            alu_shr,
   input  logic [SIZE-1:0] alu_out,
   output logic [SIZE-1:0] ac,
   output logic            z_flag,
   output logic            n_flag,
   output logic            done,
   output logic            err,
   output logic            busy
);
   state_t          r_state, w_next;
   logic [3:0]      r_op;
   logic [SHW-1:0]  r_cnt;
   logic [SIZE-1:0] r_dr, r_ac, w_ac_nxt;
   logic            r_z, r_n, w_shift, w_exec, w_ac_we, w_illegal;
   logic [8:0]      w_ctrl;

   assign w_shift = r_op == OP_SHL || r_op == OP_SHR;
   assign w_exec  = r_state == ST_EXEC;

   // A shift with a zero count spends its single EXEC cycle with every control line low
   alu_ctrl_decode u_dec (
      .i_en      (w_exec && !(w_shift && r_cnt == '0)),
      .i_op      (r_op),
      .o_ctrl    (w_ctrl),
      .o_illegal (w_illegal)
   );

   assign {alu_shr, alu_shl, alu_com, alu_xor, alu_and, alu_or, alu_sub, alu_drtac, alu_add} = w_ctrl;
   assign alu_dr    = r_dr;
   assign alu_ac    = r_ac;
   assign ac        = r_ac;
   assign z_flag    = r_z;
   assign n_flag    = r_n;
   assign req_ready = r_state == ST_IDLE;
   assign busy      = r_state != ST_IDLE;
   assign done      = r_state == ST_DONE;
   assign err       = done && w_illegal;

   // Next state and AC write: AC only ever captures the ALU while a control line is asserted, or clears on CLR
   always_comb begin
      w_next   = r_state;
      w_ac_we  = 1'b0;
      w_ac_nxt = alu_out;
      case (r_state)
         ST_IDLE: w_next = req_valid ? ST_EXEC : ST_IDLE;
         ST_EXEC: begin
            w_next   = (w_shift && r_cnt > SHW'(1)) ? ST_EXEC : ST_DONE;
            w_ac_we  = |w_ctrl || r_op == OP_CLR;
            w_ac_nxt = r_op == OP_CLR ? '0 : alu_out;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Request latch, shift counter, accumulator and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op  <= OP_NOP;
         r_dr  <= '0;
         r_cnt <= '0;
         r_ac  <= '0;
         r_z   <= 1'b1;
         r_n   <= 1'b0;
      end else begin
         if (req_ready && req_valid) begin
            r_op  <= req_op;
            r_dr  <= req_dr;
            r_cnt <= req_shamt;
         end
         if (w_exec && w_shift && r_cnt != '0) r_cnt <= r_cnt - SHW'(1);
         if (w_ac_we) begin
            r_ac <= w_ac_nxt;
            r_z  <= w_ac_nxt == '0;
            r_n  <= w_ac_nxt[SIZE-1];
         end
      end
   end
endmodule
